// File: rtl/micro_seq.sv
// micro_seq: microprogrammed sequencer with writable store, condition branching and watchdog
module micro_seq #(
    parameter int ADDR_W    = 4,
    parameter int OUT_W     = 4,
    parameter int MAX_STEPS = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_waddr,
    input  logic [5+ADDR_W+OUT_W-1:0] i_wdata,
    input  logic                      i_start,
    input  logic [ADDR_W-1:0]         i_start_addr,
    input  logic                      i_x1,
    input  logic                      i_x2,
    input  logic                      i_x3,
    output logic [OUT_W-1:0]          o_ctrl,
    output logic [ADDR_W-1:0]         o_upc,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);
    localparam int IW    = 5 + ADDR_W + OUT_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SW    = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ABORT} state_t;

    localparam logic [1:0] OP_JUMP   = 2'd1;
    localparam logic [1:0] OP_BRANCH = 2'd2;
    localparam logic [1:0] OP_HALT   = 2'd3;

    state_t            r_state, w_state_next;
    logic [IW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_upc, w_upc_next, w_upc_inc, w_target;
    logic [OUT_W-1:0]  r_ctrl, w_out;
    logic [SW-1:0]     r_steps;
    logic [IW-1:0]     w_instr;
    logic [1:0]        w_op, w_csel;
    logic              w_inv, w_cond, w_wdog;

    assign w_instr   = r_mem[r_upc];
    assign w_op      = w_instr[IW-1 -: 2];
    assign w_csel    = w_instr[IW-3 -: 2];
    assign w_inv     = w_instr[ADDR_W+OUT_W];
    assign w_target  = w_instr[OUT_W +: ADDR_W];
    assign w_out     = w_instr[OUT_W-1:0];
    assign w_cond    = (w_csel == 2'd0 ? i_x1 : w_csel == 2'd1 ? i_x2 : w_csel == 2'd2 ? i_x3 : 1'b1) ^ w_inv;
    assign w_upc_inc = r_upc + ADDR_W'(1);
    assign w_wdog    = r_steps == SW'(MAX_STEPS - 1);

    assign o_ctrl = r_ctrl;
    assign o_upc  = r_upc;
    assign o_busy = r_state == S_RUN;
    assign o_done = r_state == S_DONE;
    assign o_err  = r_state == S_ABORT;

    // Next state and next micro-PC; HALT takes priority over the watchdog
    always_comb begin
        w_state_next = r_state;
        w_upc_next   = r_upc;
        case (r_state)
            S_IDLE: begin
                w_state_next = i_start ? S_RUN : S_IDLE;
                w_upc_next   = i_start ? i_start_addr : r_upc;
            end
            S_RUN: begin
                w_upc_next   = w_op == OP_HALT ? r_upc :
                               (w_op == OP_JUMP || (w_op == OP_BRANCH && w_cond)) ? w_target : w_upc_inc;
                w_state_next = w_op == OP_HALT ? S_DONE : w_wdog ? S_ABORT : S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, micro-PC, control word and step counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_upc   <= '0;
            r_ctrl  <= '0;
            r_steps <= '0;
        end else begin
            r_state <= w_state_next;
            r_upc   <= w_upc_next;
            if (r_state == S_IDLE && i_start) r_steps <= '0;
            if (r_state == S_RUN) begin
                r_ctrl  <= w_out;
                r_steps <= r_steps + SW'(1);
            end
        end
    end

    // Microprogram store: cleared on reset, writable only while idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we && r_state == S_IDLE) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: scoreboard bench for micro_seq against a program-level reference model
module tb_micro_seq;
    localparam int AW = 4;
    localparam int OW = 4;
    localparam int MS = 64;
    localparam int IW = 5 + AW + OW;

    typedef struct {int kind; int ctrl; int upc;} ev_t;

    logic          i_clk = 0, i_rst = 1, i_we = 0, i_start = 0;
    logic          i_x1 = 0, i_x2 = 0, i_x3 = 0;
    logic [AW-1:0] i_waddr = '0, i_start_addr = '0;
    logic [IW-1:0] i_wdata = '0;
    logic [OW-1:0] o_ctrl;
    logic [AW-1:0] o_upc;
    logic          o_busy, o_done, o_err;

    int  tests = 0, fails = 0;
    int  model_mem [16];
    int  last_out = 0;
    ev_t exp_q [$];
    bit  prev_busy = 0;

    micro_seq #(.ADDR_W(AW), .OUT_W(OW), .MAX_STEPS(MS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_start(i_start), .i_start_addr(i_start_addr), .i_x1(i_x1), .i_x2(i_x2), .i_x3(i_x3),
        .o_ctrl(o_ctrl), .o_upc(o_upc), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int mk(int op, int cs, int inv, int tg, int o);
        return (op << 11) | (cs << 9) | (inv << 8) | (tg << 4) | o;
    endfunction

    // Reference: walk the program at instruction level, queueing every observable event
    function automatic void model_run(int start, bit x1, bit x2, bit x3);
        int pc = start;
        for (int s = 0; s < MS; s++) begin
            int ins = model_mem[pc];
            int op  = (ins >> 11) & 3;
            int cs  = (ins >> 9) & 3;
            int inv = (ins >> 8) & 1;
            int tg  = (ins >> 4) & 15;
            int o   = ins & 15;
            bit c   = (cs == 0 ? x1 : cs == 1 ? x2 : cs == 2 ? x3 : 1'b1) ^ inv[0];
            int nxt = op == 3 ? pc : (op == 1 || (op == 2 && c)) ? tg : (pc + 1) % 16;
            exp_q.push_back('{0, o, nxt});
            last_out = o;
            if (op == 3) begin
                exp_q.push_back('{1, 0, 0});
                return;
            end
            pc = nxt;
            if (s == MS - 1) exp_q.push_back('{2, 0, 0});
        end
    endfunction

    task automatic pop_check(int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                check("ctrl", int'(o_ctrl), e.ctrl);
                check("upc", int'(o_upc), e.upc);
            end
        end
    endtask

    // Monitor: an instruction executed on the last edge if the DUT was busy before it
    always @(negedge i_clk) begin
        if (i_rst) prev_busy = 0;
        else begin
            if (prev_busy) pop_check(0);
            if (o_done) pop_check(1);
            if (o_err) pop_check(2);
            prev_busy = o_busy;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(int a, int d);
        i_we = 1;
        i_waddr = AW'(a);
        i_wdata = IW'(d);
        tick();
        i_we = 0;
        model_mem[a] = d;
    endtask

    task automatic run(int a, bit x1, bit x2, bit x3);
        i_x1 = x1;
        i_x2 = x2;
        i_x3 = x3;
        i_start = 1;
        i_start_addr = AW'(a);
        model_run(a, x1, x2, x3);
        tick();
        i_start = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy || o_done || o_err) && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n < 300), 1);
        exp_q.delete();
    endtask

    task automatic go(int a, bit x1, bit x2, bit x3);
        run(a, x1, x2, x3);
        wait_idle();
        tick();
        check("ctrl_hold", int'(o_ctrl), last_out);
        check("busy_idle", int'(o_busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        tick();
        tick();
        i_rst = 0;
        check("rst_ctrl", int'(o_ctrl), 0);
        check("rst_upc", int'(o_upc), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);

        wr(0, mk(0, 0, 0, 0, 1));
        wr(1, mk(0, 0, 0, 0, 2));
        wr(2, mk(3, 0, 0, 0, 3));
        go(0, 0, 0, 0);

        wr(0, mk(2, 0, 0, 5, 10));
        wr(1, mk(3, 0, 0, 0, 1));
        wr(5, mk(3, 0, 0, 0, 15));
        go(0, 1, 0, 0);
        go(0, 0, 1, 1);
        wr(0, mk(2, 0, 1, 5, 10));
        go(0, 1, 0, 0);

        wr(15, mk(0, 0, 0, 0, 7));
        wr(0, mk(3, 0, 0, 0, 9));
        go(15, 0, 0, 0);

        wr(3, mk(1, 0, 0, 3, 6));
        go(3, 0, 0, 0);

        run(3, 0, 0, 0);
        tick();
        i_we = 1;
        i_waddr = AW'(3);
        i_wdata = IW'(mk(3, 0, 0, 0, 12));
        i_start = 1;
        i_start_addr = AW'(0);
        repeat (3) tick();
        i_we = 0;
        i_start = 0;
        wait_idle();
        go(3, 0, 0, 0);

        run(3, 0, 0, 0);
        repeat (5) tick();
        i_rst = 1;
        tick();
        i_rst = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        check("midrst_ctrl", int'(o_ctrl), 0);
        check("midrst_upc", int'(o_upc), 0);
        check("midrst_busy", int'(o_busy), 0);
        repeat (3) begin
            tick();
            check("midrst_pulse", int'(o_done | o_err), 0);
        end
        go(7, 0, 0, 0);

        wr(0, mk(3, 0, 0, 0, 5));
        go(0, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 16; a++)
                wr(a, mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                         $urandom_range(0, 15), $urandom_range(0, 15)));
            go($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/micro_seq.md
Name: micro_seq

Overview:
- Microprogrammed sequencer that drives the control inputs of the micro_mac automaton and similar small datapaths.
- Holds a writable microprogram store, steps a micro-PC once per clock, and branches on the condition inputs x1..x3.
- Emits a registered control word each step and runs under a start/done handshake for the top-level controller.

Parameters:
- ADDR_W, 4, micro-PC / store address width (store depth 2**ADDR_W).
- OUT_W, 4, control word width.
- MAX_STEPS, 64, watchdog limit on executed microinstructions per run (≥1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_we  input  1  store write enable (honoured only in IDLE).
- i_waddr  input  ADDR_W  store write address.
- i_wdata  input  5+ADDR_W+OUT_W  microinstruction to write.
- i_start  input  1  start request (honoured only in IDLE).
- i_start_addr  input  ADDR_W  entry address for the run.
- i_x1, i_x2, i_x3  input  1 each  condition inputs, sampled when the instruction executes.
- o_ctrl  output  OUT_W  registered control word.
- o_upc  output  ADDR_W  current micro-PC.
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse on normal HALT completion.
- o_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Instruction word, MSB to LSB: op[1:0], csel[1:0], inv, target[ADDR_W-1:0], out[OUT_W-1:0]. Default width is 13 bits.
- Condition: cond = (csel==0 ? x1 : csel==1 ? x2 : csel==2 ? x3 : 1) XOR inv.
- Ops:
  - 00 NEXT: upc <= upc+1.
  - 01 JUMP: upc <= target.
  - 10 BRANCH: upc <= cond ? target : upc+1.
  - 11 HALT: upc holds; go to DONE.
- upc+1 wraps from 2**ADDR_W-1 to 0.
- Store: register array, asynchronous read at upc, synchronous write. A write in IDLE is visible to a start in the following cycle. i_we outside IDLE is ignored.
- Reset:
  - State IDLE; upc=0; o_ctrl=0; o_busy=0; o_done=0; o_err=0; step counter=0.
  - All store entries are cleared to 0, which decodes as NEXT with out=0.
  - Reset mid-run aborts immediately with no done/err pulse.
- FSM:
  - IDLE: on i_start, upc <= i_start_addr, steps <= 0, go to RUN. o_ctrl holds its last value.
  - RUN: one instruction per cycle. o_ctrl <= out, upc <= next, steps <= steps+1.
  - RUN, HALT executed: o_ctrl <= out, go to DONE.
  - RUN, watchdog: if steps==MAX_STEPS-1 and op≠HALT, this instruction still updates o_ctrl, then go to ABORT.
  - RUN, HALT and watchdog limit in the same cycle: HALT wins and the FSM goes to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
  - ABORT: o_err=1 for one cycle, then IDLE.
- o_busy=1 exactly in RUN.
- i_start in RUN, DONE or ABORT is ignored.
- Latency: the first o_ctrl update appears 2 edges after i_start is sampled. A program of N instructions ending in HALT gives o_done N+1 cycles after the RUN entry edge.
- Conditions are sampled on the same edge that executes the instruction; there is no input registering.

Test Plan:
- Reset, then program addr0=NEXT out=1, addr1=NEXT out=2, addr2=HALT out=3; start at 0 -> o_ctrl sequence 1,2,3 on consecutive cycles; o_busy high 3 cycles; o_done pulses once; o_ctrl stays 3 in IDLE.
- Program addr0=BRANCH csel=0 inv=0 target=5 out=A, addr1=HALT out=1, addr5=HALT out=F; x1=1 -> o_ctrl A then F. Repeat with x1=0 -> A then 1. Repeat with inv=1 and x1=1 -> A then 1.
- addr15=NEXT out=7, addr0=HALT out=9; start at 15 -> upc wraps 15→0; o_ctrl 7 then 9; o_done pulses.
- Single-instruction loop: addr3=JUMP target=3; MAX_STEPS=64; start at 3 -> exactly 64 RUN cycles, then o_err pulse, no o_done, return to IDLE.
- i_start and i_we asserted during RUN -> store contents and run unchanged. Assert i_rst mid-run -> next cycle IDLE, o_ctrl=0, store cleared, no done/err pulse.
- Write addr0=HALT out=5 and assert i_start in the next cycle -> the new instruction executes and o_ctrl=5.
